// File: rtl/text_console_writer.sv
// Byte-stream text console: turns printable/control bytes into character-RAM cell writes plus a cursor.
// One write per cycle; in_ready drops for the whole of any write sequence (PUT, line clear, screen clear).
module text_console_writer #(
    parameter int         COLUMNS    = 80,
    parameter int         ROWS       = 30,
    parameter logic [6:0] BLANK_CHAR = 7'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        gram_we,
    output logic [11:0] gram_write_address,
    output logic [6:0]  gram_write_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PUT        = 2'd1;
    localparam logic [1:0] CLR_LINE   = 2'd2;
    localparam logic [1:0] CLR_SCREEN = 2'd3;

    localparam logic [11:0] LAST_ADDR = 12'(COLUMNS * ROWS - 1);
    localparam logic [11:0] COLS_12   = 12'(COLUMNS);
    localparam logic [6:0]  LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [6:0]  LINE_LEN  = 7'(COLUMNS);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

    logic [1:0]  state;
    logic        pend_clr;   // the current PUT wrapped the cursor, so a line clear follows
    logic [6:0]  clr_cnt;
    logic [4:0]  row_nxt;
    logic [11:0] cell_addr;
    logic        accept;
    logic        printable;

    function automatic logic [11:0] row_base(input logic [4:0] r);
        return 12'(r) * COLS_12;
    endfunction

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign row_nxt   = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    assign cell_addr = row_base(cursor_row) + 12'(cursor_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= CLR_SCREEN;
            pend_clr           <= 1'b0;
            clr_cnt            <= 7'd0;
            gram_we            <= 1'b0;
            gram_write_address <= 12'd0;
            gram_write_data    <= 7'd0;
            cursor_col         <= 7'd0;
            cursor_row         <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    gram_we <= 1'b0;
                    if (accept) begin
                        if (printable) begin
                            state              <= PUT;
                            gram_we            <= 1'b1;
                            gram_write_address <= cell_addr;
                            gram_write_data    <= in_data[6:0];
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 7'd0;
                                cursor_row <= row_nxt;
                                pend_clr   <= 1'b1;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                                pend_clr   <= 1'b0;
                            end
                        end else if (in_data == 8'h0A) begin
                            cursor_col         <= 7'd0;
                            cursor_row         <= row_nxt;
                            state              <= CLR_LINE;
                            gram_we            <= 1'b1;
                            gram_write_address <= row_base(row_nxt);
                            gram_write_data    <= BLANK_CHAR;
                            clr_cnt            <= 7'd1;
                        end else if (in_data == 8'h0D) begin
                            cursor_col <= 7'd0;
                        end else if (in_data == 8'h08) begin
                            // Backspace never wraps to the previous row
                            if (cursor_col != 7'd0) begin
                                cursor_col         <= cursor_col - 7'd1;
                                state              <= PUT;
                                gram_we            <= 1'b1;
                                gram_write_address <= cell_addr - 12'd1;
                                gram_write_data    <= BLANK_CHAR;
                                pend_clr           <= 1'b0;
                            end
                        end else if (in_data == 8'h0C) begin
                            cursor_col         <= 7'd0;
                            cursor_row         <= 5'd0;
                            state              <= CLR_SCREEN;
                            gram_we            <= 1'b1;
                            gram_write_address <= 12'd0;
                            gram_write_data    <= BLANK_CHAR;
                        end
                    end
                end
                PUT: begin
                    if (pend_clr) begin
                        pend_clr           <= 1'b0;
                        state              <= CLR_LINE;
                        gram_write_address <= row_base(cursor_row);
                        gram_write_data    <= BLANK_CHAR;
                        clr_cnt            <= 7'd1;
                    end else begin
                        state   <= IDLE;
                        gram_we <= 1'b0;
                    end
                end
                CLR_LINE: begin
                    if (clr_cnt == LINE_LEN) begin
                        state   <= IDLE;
                        gram_we <= 1'b0;
                    end else begin
                        gram_write_address <= gram_write_address + 12'd1;
                        clr_cnt            <= clr_cnt + 7'd1;
                    end
                end
                default: begin
                    // Out of reset gram_we is low, so the first cycle here issues address 0
                    gram_write_data <= BLANK_CHAR;
                    if (!gram_we) begin
                        gram_we            <= 1'b1;
                        gram_write_address <= 12'd0;
                    end else if (gram_write_address == LAST_ADDR) begin
                        state   <= IDLE;
                        gram_we <= 1'b0;
                    end else begin
                        gram_write_address <= gram_write_address + 12'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a cursor model predicts every GRAM write, a negedge monitor pops and compares.
module tb_text_console_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        gram_we;
    logic [11:0] gram_write_address;
    logic [6:0]  gram_write_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_console_writer #(.COLUMNS(COLS), .ROWS(ROWS), .BLANK_CHAR(7'h20)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .gram_we            (gram_we),
        .gram_write_address (gram_write_address),
        .gram_write_data    (gram_write_data),
        .cursor_col         (cursor_col),
        .cursor_row         (cursor_row)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_count = 0;
    int m_col = 0;
    int m_row = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && gram_we) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("spurious_write_addr", int'(gram_write_address), -1);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("wr_addr", int'(gram_write_address), int'(e[18:7]));
                check("wr_data", int'(gram_write_data), int'(e[6:0]));
            end
        end
    end

    task automatic push(input int addr, input int data);
        exp_q.push_back({12'(addr), 7'(data)});
    endtask

    task automatic push_line(input int row);
        for (int i = 0; i < COLS; i++) push(row * COLS + i, 8'h20);
    endtask

    task automatic push_screen();
        for (int i = 0; i < COLS * ROWS; i++) push(i, 8'h20);
    endtask

    task automatic row_adv();
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        push_line(m_row);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(m_row * COLS + m_col, int'(b[6:0]));
            if (m_col == COLS - 1) begin
                m_col = 0;
                row_adv();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            row_adv();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push(m_row * COLS + m_col, 8'h20);
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_screen();
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check({tag, "_timeout"}, 0, 1);
    endtask

    // Sends one byte and returns how many cycles in_ready stayed low afterwards
    task automatic send(input logic [7:0] b, output int low);
        wait_ready("pre_send");
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(b);
        low = 0;
        @(negedge clk);
        while (!in_ready && low < 5000) begin
            low++;
            @(negedge clk);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, int'(cursor_col), m_col);
        check({tag, "_row"}, int'(cursor_row), m_row);
    endtask

    initial begin
        int low;
        int n;

        #12;
        check("rst_we", int'(gram_we), 0);
        check("rst_addr", int'(gram_write_address), 0);
        check("rst_data", int'(gram_write_data), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);

        push_screen();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_clear");
        check("init_writes", wr_count, 2400);
        check("init_ready", int'(in_ready), 1);
        check("init_col", int'(cursor_col), 0);
        check("init_row", int'(cursor_row), 0);

        send(8'h41, low);
        check("A_ready_low", low, 1);
        check("A_col", int'(cursor_col), 1);
        check("A_row", int'(cursor_row), 0);

        for (int i = 0; i < 78; i++) send(8'(8'h21 + i), low);
        check_cursor("at_col79");
        check("col79", int'(cursor_col), 79);
        send(8'h5A, low);
        check("wrap_ready_low", low, 81);
        check("wrap_col", int'(cursor_col), 0);
        check("wrap_row", int'(cursor_row), 1);

        send(8'h0A, low);
        check("lf_ready_low", low, 80);
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i), low);
        check_cursor("at_5_2");
        wr_count = 0;
        send(8'h08, low);
        check("bs_writes", wr_count, 1);
        check("bs_col", int'(cursor_col), 4);
        check("bs_row", int'(cursor_row), 2);

        send(8'h0D, low);
        check("cr_ready_low", low, 0);
        check_cursor("after_cr");
        wr_count = 0;
        send(8'h08, low);
        check("bs0_ready_low", low, 0);
        check("bs0_writes", wr_count, 0);
        check("bs0_col", int'(cursor_col), 0);
        check("bs0_row", int'(cursor_row), 2);
        send(8'h07, low);
        send(8'hFF, low);
        send(8'h7F, low);
        check("discard_writes", wr_count, 0);
        check_cursor("after_discard");

        for (int i = 0; i < 27; i++) send(8'h0A, low);
        check("row29", int'(cursor_row), 29);
        send(8'h0A, low);
        check("lf_wrap_col", int'(cursor_col), 0);
        check("lf_wrap_row", int'(cursor_row), 0);

        for (int i = 0; i < 7; i++) send(8'h0A, low);
        for (int i = 0; i < 10; i++) send(8'h30, low);
        check_cursor("at_10_7");

        // Form feed, then reset in the middle of the screen clear
        wait_ready("pre_ff");
        in_data  = 8'h0C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(8'h0C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gram_we && gram_write_address == 12'd1000) && n < 5000);
        check("ff_reached_1000", int'(gram_write_address), 1000);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_we", int'(gram_we), 0);
        check("midrst_ready", int'(in_ready), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("midrst_we_hold", int'(gram_we), 0);
        push_screen();
        wr_count = 0;
        rst_n = 1'b1;
        wait_ready("rst_clear");
        check("rst_clear_writes", wr_count, 2400);
        check("rst_clear_col", int'(cursor_col), 0);
        check("rst_clear_row", int'(cursor_row), 0);

        send(8'h42, low);
        check("post_rst_col", int'(cursor_col), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLUMNS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen.
REQ-003 SHALL have parameter BLANK_CHAR, default 7'h20, meaning the code written when clearing cells.
REQ-004 SHALL have port clk  input  1  system/pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  8  incoming character/control byte.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-009 SHALL have port gram_we  output  1  GRAM write strobe, one cell per cycle.
REQ-010 SHALL have port gram_write_address  output  12  cell index row*COLUMNS+col, range 0..COLUMNS*ROWS-1.
REQ-011 SHALL have port gram_write_data  output  7  ASCII code written to the cell.
REQ-012 SHALL have port cursor_col  output  7  current cursor column, 0..COLUMNS-1.
REQ-013 SHALL have port cursor_row  output  5  current cursor row, 0..ROWS-1.

Function
REQ-014 SHALL implement states IDLE, PUT, CLR_LINE, CLR_SCREEN; in_ready SHALL be 1 exactly when state is IDLE.
REQ-015 SHALL accept a byte on a rising edge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-016 SHALL register gram_we, gram_write_address and gram_write_data; gram_we SHALL be 1 exactly during PUT, CLR_LINE and CLR_SCREEN cycles.
REQ-017 Printable byte 0x20-0x7E: SHALL enter PUT for one cycle, writing in_data[6:0] at the pre-advance cursor address, with cursor advanced at the same edge.
REQ-018 Cursor advance: col+1; at col COLUMNS-1, col becomes 0 and a row advance occurs.
REQ-019 Row advance: row+1, or 0 when row is ROWS-1; every row advance SHALL be followed by CLR_LINE on the new row.
REQ-020 CLR_LINE: COLUMNS consecutive writes of BLANK_CHAR at addresses new_row*COLUMNS .. new_row*COLUMNS+COLUMNS-1 ascending, then IDLE.
REQ-021 After a printable at col COLUMNS-1, PUT SHALL be followed directly by CLR_LINE with no IDLE cycle between.
REQ-022 LF 0x0A: col becomes 0 with a row advance; CLR_LINE SHALL start the cycle after acceptance.
REQ-023 CR 0x0D: col becomes 0, row unchanged; no write; state stays IDLE.
REQ-024 BS 0x08 with col>0: col-1, then PUT writing BLANK_CHAR at the new position.
REQ-025 BS 0x08 with col=0: no-op, stays IDLE; the cursor SHALL NOT move to the previous row.
REQ-026 FF 0x0C: cursor becomes (0,0), then CLR_SCREEN.
REQ-027 CLR_SCREEN: COLUMNS*ROWS consecutive BLANK_CHAR writes at addresses 0..COLUMNS*ROWS-1 ascending, then IDLE.
REQ-028 Any other byte (0x00-0x1F except those above, 0x7F-0xFF) SHALL be discarded: accepted, no write, cursor unchanged, stays IDLE.
REQ-029 Address arithmetic SHALL be 12-bit unsigned and never exceed COLUMNS*ROWS-1.
REQ-030 in_ready SHALL return to 1 on the cycle after the last write of any sequence.

Reset
REQ-031 While rst_n=0: gram_we=0, gram_write_address=0, gram_write_data=0, cursor=(0,0), in_ready=0, state=CLR_SCREEN with clear counter 0.
REQ-032 After rst_n deasserts, the block SHALL perform a full CLR_SCREEN before first asserting in_ready.
REQ-033 Reset asserted mid-sequence SHALL drop gram_we immediately (asynchronously); on release the clear SHALL restart from address 0.

Verification
REQ-034 Reset release -> 2400 consecutive gram_we cycles, addresses 0..2399, data 0x20; then in_ready=1 and cursor (0,0).
REQ-035 0x41 at (0,0) -> single write, addr 0, data 0x41; in_ready low exactly 1 cycle; cursor (1,0).
REQ-036 0x5A at (79,0) -> write addr 79 data 0x5A, then 80 writes addr 80..159 data 0x20; cursor (0,1); in_ready low 81 cycles.
REQ-037 LF at row 29 -> 80 writes addr 0..79 data 0x20; cursor (0,0).
REQ-038 BS at (5,2) -> write addr 164 data 0x20, cursor (4,2); BS at (0,2) -> no write, in_ready stays 1; 0x07 -> no write, cursor unchanged.
REQ-039 FF at (10,7), then rst_n pulsed low at clear address 1000 -> gram_we 0 during reset; after release the clear restarts at addr 0 and completes all 2400 writes.
